// File: rtl/axi_crossbar_mst_rd_if.sv
// Master-side AXI3 read interface: decodes the target slave, registers AR into the switch bus, passes R through.
// Latency: AR 1 cycle (one-entry output register, 1 AR/cycle); R combinational pass-through.
// Backpressure: AR stalls on a full output register, the outstanding limit, or a slave change while reads are in flight.
module axi_crossbar_mst_rd_if #(
    parameter int AXI_ADDR_W      = 32,
    parameter int AXI_ID_W        = 4,
    parameter int AXI_DATA_W      = 32,
    parameter int SLV_NUM         = 4,
    parameter int MST_OSTDREQ_NUM = 4,
    parameter int SLV_SEL_W       = $clog2(SLV_NUM),
    parameter int CNT_W           = $clog2(MST_OSTDREQ_NUM + 1),
    parameter int ARCH_W          = AXI_ADDR_W + AXI_ID_W + 11,
    parameter int RCH_W           = AXI_DATA_W + AXI_ID_W + 2
) (
    input  logic                  i_aclk,
    input  logic                  i_srst,
    input  logic                  i_arvalid,
    output logic                  i_arready,
    input  logic [AXI_ADDR_W-1:0] i_araddr,
    input  logic [3:0]            i_arlen,
    input  logic [2:0]            i_arsize,
    input  logic [1:0]            i_arburst,
    input  logic [AXI_ID_W-1:0]   i_arid,
    input  logic [1:0]            i_arlock,
    output logic                  i_rvalid,
    input  logic                  i_rready,
    output logic [AXI_ID_W-1:0]   i_rid,
    output logic [1:0]            i_rresp,
    output logic [AXI_DATA_W-1:0] i_rdata,
    output logic                  i_rlast,
    output logic                  o_arvalid,
    input  logic                  o_arready,
    output logic [ARCH_W-1:0]     o_arch,
    output logic [SLV_SEL_W-1:0]  o_arsel,
    input  logic                  o_rvalid,
    output logic                  o_rready,
    input  logic [RCH_W-1:0]      o_rch,
    input  logic                  o_rlast,
    output logic                  o_err
);

    logic                 arvalid_q, arvalid_d;
    logic [ARCH_W-1:0]    arch_q, arch_d;
    logic [SLV_SEL_W-1:0] arsel_q, arsel_d;
    logic [SLV_SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0]     ostd_cnt_q, ostd_cnt_d;
    logic                 err_q, err_d;

    logic [SLV_SEL_W-1:0] sel;
    logic                 admit;
    logic                 ar_acc;
    logic                 r_hs;
    logic                 r_done;

    assign sel    = i_araddr[AXI_ADDR_W-1 -: SLV_SEL_W];
    // All in-flight reads must target one slave so R beats cannot reorder across slaves.
    assign admit  = (ostd_cnt_q < CNT_W'(MST_OSTDREQ_NUM)) &&
                    ((ostd_cnt_q == '0) || (sel == cur_sel_q));
    assign i_arready = (~arvalid_q | o_arready) & admit;
    assign ar_acc = i_arvalid & i_arready;
    assign r_hs   = o_rvalid & i_rready;
    assign r_done = r_hs & o_rlast;

    assign i_rvalid = o_rvalid;
    assign o_rready = i_rready;
    assign i_rlast  = o_rlast;
    assign {i_rdata, i_rresp, i_rid} = o_rch;

    assign o_arvalid = arvalid_q;
    assign o_arch    = arch_q;
    assign o_arsel   = arsel_q;
    assign o_err     = err_q;

    always_comb begin
        arvalid_d  = arvalid_q;
        arch_d     = arch_q;
        arsel_d    = arsel_q;
        cur_sel_d  = cur_sel_q;
        ostd_cnt_d = ostd_cnt_q;
        err_d      = err_q;

        if (ar_acc) begin
            arvalid_d = 1'b1;
            arch_d    = {i_arlock, i_arburst, i_arsize, i_arlen, i_arid, i_araddr};
            arsel_d   = sel;
            cur_sel_d = sel;
        end else if (o_arready) begin
            arvalid_d = 1'b0;
        end

        // A stray last beat with nothing outstanding must not wrap the counter.
        if (ar_acc && !r_done) begin
            ostd_cnt_d = ostd_cnt_q + CNT_W'(1);
        end else if (r_done && !ar_acc && (ostd_cnt_q != '0)) begin
            ostd_cnt_d = ostd_cnt_q - CNT_W'(1);
        end

        if (r_hs && (ostd_cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_srst) begin
            arvalid_q  <= 1'b0;
            arch_q     <= '0;
            arsel_q    <= '0;
            cur_sel_q  <= '0;
            ostd_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            arvalid_q  <= arvalid_d;
            arch_q     <= arch_d;
            arsel_q    <= arsel_d;
            cur_sel_q  <= cur_sel_d;
            ostd_cnt_q <= ostd_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_crossbar_mst_rd_if.sv
// Randomized and directed bench for axi_crossbar_mst_rd_if with a queue-based reference model.
module tb_axi_crossbar_mst_rd_if;
    localparam int AW = 32, IW = 4, DW = 32, SN = 4, OSTD = 4;
    localparam int SW = 2;
    localparam int ARCH_W = AW + IW + 11;
    localparam int RCH_W  = DW + IW + 2;

    logic              i_aclk = 1'b0;
    logic              i_srst;
    logic              i_arvalid, i_arready;
    logic [AW-1:0]     i_araddr;
    logic [3:0]        i_arlen;
    logic [2:0]        i_arsize;
    logic [1:0]        i_arburst, i_arlock, i_rresp;
    logic [IW-1:0]     i_arid, i_rid;
    logic              i_rvalid, i_rready, i_rlast;
    logic [DW-1:0]     i_rdata;
    logic              o_arvalid, o_arready;
    logic [ARCH_W-1:0] o_arch;
    logic [SW-1:0]     o_arsel;
    logic              o_rvalid, o_rready, o_rlast, o_err;
    logic [RCH_W-1:0]  o_rch;

    axi_crossbar_mst_rd_if #(
        .AXI_ADDR_W(AW), .AXI_ID_W(IW), .AXI_DATA_W(DW),
        .SLV_NUM(SN), .MST_OSTDREQ_NUM(OSTD)
    ) dut (
        .i_aclk(i_aclk), .i_srst(i_srst),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_araddr(i_araddr),
        .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
        .i_arid(i_arid), .i_arlock(i_arlock),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rid(i_rid),
        .i_rresp(i_rresp), .i_rdata(i_rdata), .i_rlast(i_rlast),
        .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
        .o_arsel(o_arsel), .o_rvalid(o_rvalid), .o_rready(o_rready),
        .o_rch(o_rch), .o_rlast(o_rlast), .o_err(o_err)
    );

    always #5 i_aclk = ~i_aclk;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding burst count, the slave they target, sticky error,
    // and the ARs accepted but not yet taken by the switch (in order).
    int              m_ostd    = 0;
    int              m_cur_sel = 0;
    bit              m_err     = 1'b0;
    bit              mon_en    = 1'b0;
    logic [ARCH_W-1:0] exp_arch_q[$];
    int                exp_sel_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the switch-side AR stream must match the accepted requests in order and stay stable while stalled.
    always @(negedge i_aclk) begin
        #1;
        if (mon_en) begin
            chk("o_arvalid", {63'd0, o_arvalid}, {63'd0, exp_arch_q.size() != 0});
            chk("o_err", {63'd0, o_err}, {63'd0, m_err});
            if (o_arvalid && exp_arch_q.size() != 0) begin
                chk("o_arch", 64'(o_arch), 64'(exp_arch_q[0]));
                chk("o_arsel", 64'(o_arsel), 64'(exp_sel_q[0]));
                if (o_arready) begin
                    void'(exp_arch_q.pop_front());
                    void'(exp_sel_q.pop_front());
                end
            end
        end
    end

    task automatic cycle(input bit srst, input bit arv, input logic [AW-1:0] addr,
                         input logic [3:0] len, input logic [IW-1:0] id,
                         input bit arrdy, input bit rv, input bit rrdy, input bit rl);
        int  sel;
        bit  exp_rdy, acc, rhs, rdone;
        @(negedge i_aclk);
        i_srst    = srst;
        i_arvalid = arv;
        i_araddr  = addr;
        i_arlen   = len;
        i_arid    = id;
        i_arsize  = 3'($urandom_range(0, 7));
        i_arburst = 2'($urandom_range(0, 3));
        i_arlock  = 2'($urandom_range(0, 3));
        o_arready = arrdy;
        o_rvalid  = rv;
        i_rready  = rrdy;
        o_rlast   = rl;
        o_rch     = {$urandom, $urandom};
        #2;
        sel     = int'(addr[AW-1 -: SW]);
        exp_rdy = (exp_arch_q.size() == 0) && (m_ostd < OSTD) &&
                  (m_ostd == 0 || sel == m_cur_sel);
        chk("i_arready", {63'd0, i_arready}, {63'd0, exp_rdy});
        chk("r_passthru", {i_rvalid, o_rready, i_rlast, i_rdata, i_rresp, i_rid},
            {rv, rrdy, rl, o_rch});
        if (exp_arch_q.size() > 1) chk("ar_q_depth", 64'(exp_arch_q.size()), 64'd1);
        acc   = arv && exp_rdy;
        rhs   = rv && rrdy;
        rdone = rhs && rl;
        if (srst) begin
            m_ostd = 0; m_cur_sel = 0; m_err = 1'b0;
            exp_arch_q.delete(); exp_sel_q.delete();
        end else begin
            if (rhs && m_ostd == 0) m_err = 1'b1;
            if (acc) begin
                exp_arch_q.push_back({i_arlock, i_arburst, i_arsize, len, id, addr});
                exp_sel_q.push_back(sel);
                m_cur_sel = sel;
            end
            if (acc && !rdone)                    m_ostd++;
            else if (rdone && !acc && m_ostd > 0) m_ostd--;
        end
    endtask

    task automatic idle(input bit arrdy);
        cycle(0, 0, '0, 0, 0, arrdy, 0, 0, 0);
    endtask

    task automatic rbeat(input bit last);
        cycle(0, 0, '0, 0, 0, 1, 1, 1, last);
    endtask

    initial begin
        i_srst = 1'b1; i_arvalid = 0; i_araddr = '0; i_arlen = 0; i_arsize = 0;
        i_arburst = 0; i_arid = 0; i_arlock = 0; o_arready = 0; o_rvalid = 0;
        i_rready = 0; o_rch = '0; o_rlast = 0;
        repeat (2) @(posedge i_aclk);
        mon_en = 1'b1;
        cycle(1, 0, '0, 0, 0, 0, 0, 0, 0);

        // Single burst to slave 1, four beats, then a different slave is admissible again.
        cycle(0, 1, 32'h4000_0010, 4'd3, 4'd5, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) rbeat(i == 3);
        cycle(0, 1, 32'hC000_0000, 4'd0, 4'd1, 1, 0, 0, 0);
        rbeat(1);

        // Fill to the outstanding limit, fifth waits for a last beat.
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'h8000_0000, 4'(i), 4'(i), 1, 0, 0, 0);
        cycle(0, 1, 32'h8000_0000, 4'd4, 4'd4, 1, 0, 0, 0);
        cycle(0, 1, 32'h8000_0000, 4'd4, 4'd4, 1, 1, 1, 1);
        cycle(0, 1, 32'h8000_0000, 4'd4, 4'd4, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) rbeat(1);

        // Slave change blocked until the slave-0 burst drains.
        cycle(0, 1, 32'h0000_0100, 4'd1, 4'd2, 1, 0, 0, 0);
        cycle(0, 1, 32'hC000_0000, 4'd0, 4'd3, 1, 1, 1, 0);
        cycle(0, 1, 32'hC000_0000, 4'd0, 4'd3, 1, 1, 1, 1);
        cycle(0, 1, 32'hC000_0000, 4'd0, 4'd3, 1, 0, 0, 0);
        rbeat(1);

        // Switch stall: request held stable for five cycles, emitted once.
        cycle(0, 1, 32'h4000_0040, 4'd2, 4'd6, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'h4000_0080, 4'd1, 4'd7, 0, 0, 0, 0);
        idle(1);
        idle(1);
        rbeat(1);
        rbeat(1);

        // Accept and last beat in the same cycle keep the count at one.
        cycle(0, 1, 32'h8000_1000, 4'd0, 4'd8, 1, 0, 0, 0);
        cycle(0, 1, 32'h8000_2000, 4'd0, 4'd9, 1, 1, 1, 1);
        cycle(0, 1, 32'h0000_0000, 4'd0, 4'd1, 1, 0, 0, 0);
        rbeat(1);
        cycle(0, 1, 32'h0000_0000, 4'd0, 4'd1, 1, 0, 0, 0);
        rbeat(1);

        // Unexpected beat raises a sticky error that only reset clears.
        rbeat(0);
        repeat (3) idle(1);
        cycle(1, 0, '0, 0, 0, 1, 0, 0, 0);
        idle(1);

        for (int n = 0; n < 3000; n++) begin
            bit rv;
            rv = (m_ostd > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom,
                  4'($urandom), 4'($urandom), $urandom_range(0, 9) < 7, rv,
                  $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4);
        end
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
